alu_rr_arbiter: RTL and testbench
=================================

# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one MiniAlu execution datapath among several requesters. It accepts operation requests (opcode plus two operands) and grants the ALU to one requester at a time. It issues the operation, waits a fixed ALU latency, captures the result and returns it with a one-cycle done pulse. It sits between the requesting control blocks and the MiniAlu operand/result ports.

## Interface
- NREQ, 4: number of requesters (2..8).
- DW, 16: operand/result width.
- OPW, 4: opcode width.
- ALU_LAT, 2: cycles from the oAluStart cycle to iAluResult valid (≥1).
- LOCK_MAX, 4: maximum back-to-back ops per locked grant (ARB_LOCK_EN only).

- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- iReq  in  NREQ  request per requester; held until that requester's oDone.
- iOp  in  NREQ*OPW  opcodes; requester i at [i*OPW +: OPW].
- iA, iB  in  NREQ*DW  operands; requester i at [i*DW +: DW].
- iLock  in  NREQ  keep grant for a following op (ignored without ARB_LOCK_EN).
- iAluResult  in  DW  ALU result.
- oAluOp  out  OPW  latched opcode to ALU.
- oAluA, oAluB  out  DW  latched operands to ALU.
- oAluStart  out  1  one-cycle issue strobe.
- oGrant  out  NREQ  one-hot owner, high from ISSUE through DONE.
- oDone  out  NREQ  one-hot, one-cycle completion pulse.
- oResult  out  DW  captured result; holds until the next DONE.
- oBusy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any iReq, pick the first set bit scanning from ptr+1 mod NREQ upward. Register index idx. Latch iOp/iA/iB of idx into oAluOp/oAluA/oAluB. Set oGrant[idx]. Go to ISSUE.
  - ISSUE: oAluStart=1. Load wait counter with ALU_LAT-1. Go to WAIT.
  - WAIT: decrement counter. When counter is 0: oResult←iAluResult, oDone[idx]←1, go to DONE.
  - DONE: oDone pulse visible this cycle. ptr←idx. Clear oGrant. Go to IDLE.
- Requester deasserting iReq after grant does not abort the op. It completes and oDone still pulses.
- iReq still high in the cycle after oDone is treated as a new request and competes normally.
- Operands are sampled only in IDLE→ISSUE. Later changes on iA/iB/iOp are ignored for the current op.
- oAluOp/oAluA/oAluB hold their last values in IDLE.
- Reset, asynchronous and effective immediately, including mid-operation:
  - state=IDLE, ptr=NREQ-1 (requester 0 wins first), counter=0, lock count=0.
  - All outputs 0. An in-flight op is dropped and no oDone is produced.

## Timing
- Request sampled high in IDLE at cycle 0:
  - cycle 1: oGrant and oAlu* valid (ISSUE), oAluStart=1.
  - cycles 2..ALU_LAT+1: WAIT.
  - cycle ALU_LAT+2: oDone and new oResult valid (DONE).
  - cycle ALU_LAT+3: IDLE, earliest next arbitration.
- Throughput: one op per ALU_LAT+3 cycles. Worst-case wait for any asserted requester: NREQ-1 ops.
- With ALU_LAT=1, WAIT lasts one cycle (the counter-zero cycle).

## Configuration
- ARB_LOCK_EN defined:
  - In WAIT→DONE, if iLock[idx] && iReq[idx] && lock count < LOCK_MAX-1: increment lock count and mark locked.
  - When locked, DONE goes straight to ISSUE. Fresh operands of idx are latched on that edge, oGrant stays high, and ptr is not updated.
  - Otherwise normal DONE→IDLE, and the lock count clears.
- ARB_LOCK_EN undefined: iLock is ignored, there is no lock counter, and every op returns to IDLE.

## Test plan
- Reset mid-WAIT with ALU_LAT=2 → all outputs 0 immediately, no oDone. A request at the next cycle grants requester 0 behaviour per ptr reset.
- Single request on requester 2 (op=ADD, A=0x0003, B=0x0004, ALU model returns 0x0007) → oAluStart at cycle 1, oDone=4'b0100 at cycle 4, oResult=0x0007.
- All four iReq held continuously → grants in order 0,1,2,3,0, one op every 5 cycles, no requester skipped.
- Requester 1 drops iReq in cycle 2 → op completes, oDone[1] pulses at cycle 4, no re-grant to 1.
- Operands of the granted requester change during WAIT → oResult reflects the operands latched at ISSUE.
- ARB_LOCK_EN, LOCK_MAX=4, requester 3 holds iLock and iReq, requester 0 also requesting → requester 3 gets 4 consecutive ops with oGrant[3] continuously high, then requester 0 is granted. Without the macro, grants alternate 3,0.

Source files
------------

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of the requester-side and ALU-side signals of alu_rr_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// view of the environment that drives requests and the ALU result.
interface alu_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int OPW  = 4
);
  logic [NREQ-1:0]     i_req;
  logic [NREQ*OPW-1:0] i_op;
  logic [NREQ*DW-1:0]  i_a;
  logic [NREQ*DW-1:0]  i_b;
  logic [NREQ-1:0]     i_lock;
  logic [DW-1:0]       i_alu_result;
  logic [OPW-1:0]      o_alu_op;
  logic [DW-1:0]       o_alu_a;
  logic [DW-1:0]       o_alu_b;
  logic                o_alu_start;
  logic [NREQ-1:0]     o_grant;
  logic [NREQ-1:0]     o_done;
  logic [DW-1:0]       o_result;
  logic                o_busy;

  modport slave (
    input  i_req, i_op, i_a, i_b, i_lock, i_alu_result,
    output o_alu_op, o_alu_a, o_alu_b, o_alu_start,
           o_grant, o_done, o_result, o_busy
  );

  modport master (
    output i_req, i_op, i_a, i_b, i_lock, i_alu_result,
    input  o_alu_op, o_alu_a, o_alu_b, o_alu_start,
           o_grant, o_done, o_result, o_busy
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one MiniAlu among NREQ requesters.
// Optional feature: define ARB_LOCK_EN to let a requester keep the grant
// for up to LOCK_MAX back-to-back operations.
//
// state  | meaning
// IDLE   | no op in flight; arbitrate among i_req
// ISSUE  | operands presented, o_alu_start high, wait counter loaded
// WAIT   | counting down the ALU latency; capture result at zero
// DONE   | o_done pulse; release grant (or re-issue when locked)
module alu_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 16,
  parameter int OPW      = 4,
  parameter int ALU_LAT  = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  alu_rr_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [OPW-1:0]  r_alu_op;
  logic [DW-1:0]   r_alu_a;
  logic [DW-1:0]   r_alu_b;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [DW-1:0]   r_result;

  logic            w_any;
  logic [IW-1:0]   w_pick;
  logic            w_relock;

  // First requesting index scanning upward from r_ptr+1 (wrapping).
  // The loop runs from the farthest candidate down so the nearest one wins.
  always_comb begin
    int j;
    w_any  = |bus.i_req;
    w_pick = r_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (bus.i_req[j]) w_pick = IW'(j);
    end
  end

`ifdef ARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);
  logic [LCW-1:0] r_lock_cnt;
  logic           r_locked;

  // Decide at result capture whether the owner keeps the grant; the count
  // only clears when the grant is really released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (r_state == S_WAIT && r_cnt == '0) begin
      if (bus.i_lock[r_idx] && bus.i_req[r_idx] &&
          r_lock_cnt < LCW'(LOCK_MAX - 1)) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
        r_locked   <= 1'b1;
      end else begin
        r_locked   <= 1'b0;
      end
    end else if (r_state == S_DONE && !r_locked) begin
      r_lock_cnt <= '0;
    end
  end

  assign w_relock = r_locked;
`else
  wire w_unused_lock = ^bus.i_lock;
  assign w_relock = 1'b0;
`endif

  // Main sequencer: arbitration, operand latching, latency count, completion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= IW'(NREQ - 1);
      r_idx    <= '0;
      r_cnt    <= '0;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx    <= w_pick;
            r_alu_op <= bus.i_op[w_pick*OPW +: OPW];
            r_alu_a  <= bus.i_a[w_pick*DW +: DW];
            r_alu_b  <= bus.i_b[w_pick*DW +: DW];
            r_grant  <= NREQ'(1) << w_pick;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CW'(ALU_LAT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_result <= bus.i_alu_result;
            r_done   <= NREQ'(1) << r_idx;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_done <= '0;
          if (w_relock) begin
            r_alu_op <= bus.i_op[r_idx*OPW +: OPW];
            r_alu_a  <= bus.i_a[r_idx*DW +: DW];
            r_alu_b  <= bus.i_b[r_idx*DW +: DW];
            r_state  <= S_ISSUE;
          end else begin
            r_ptr   <= r_idx;
            r_grant <= '0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_alu_op    = r_alu_op;
  assign bus.o_alu_a     = r_alu_a;
  assign bus.o_alu_b     = r_alu_b;
  assign bus.o_alu_start = (r_state == S_ISSUE);
  assign bus.o_grant     = r_grant;
  assign bus.o_done      = r_done;
  assign bus.o_result    = r_result;
  assign bus.o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small MiniAlu latency model.
module tb_alu_rr_arbiter;
  localparam int NREQ = 4, DW = 16, OPW = 4, ALU_LAT = 2, LOCK_MAX = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR = 4'd3, OP_XOR = 4'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  alu_rr_arbiter_if #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) bus ();

  alu_rr_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .ALU_LAT(ALU_LAT),
                   .LOCK_MAX(LOCK_MAX)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a;
    endcase
  endfunction

  // ALU model: result valid ALU_LAT cycles after the start cycle, junk otherwise.
  logic [15:0] stg [ALU_LAT];
  always @(posedge clk) begin
    stg[0] <= bus.o_alu_start ? alu_f(bus.o_alu_op, bus.o_alu_a, bus.o_alu_b) : 16'hDEAD;
    for (int s = 1; s < ALU_LAT; s++) stg[s] <= stg[s-1];
  end
  assign bus.i_alu_result = stg[ALU_LAT-1];

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
  } vec_t;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int idx, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.i_op[idx*OPW +: OPW] = op;
    bus.i_a[idx*DW +: DW]    = a;
    bus.i_b[idx*DW +: DW]    = b;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int owner(logic [3:0] g);
    int o = -1;
    for (int k = 0; k < NREQ; k++) if (g[k]) o = k;
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    int   nst, run, own [5], exp_own [5], exp_run;
    logic cont;

    vt[0] = '{2, OP_ADD, 16'h0003, 16'h0004, 16'h0007};
    vt[1] = '{0, OP_SUB, 16'h0010, 16'h0001, 16'h000F};
    vt[2] = '{1, OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0};
    vt[3] = '{3, OP_OR,  16'h1200, 16'h0034, 16'h1234};
    vt[4] = '{2, OP_XOR, 16'hFFFF, 16'h00FF, 16'hFF00};
    vt[5] = '{0, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF};

    bus.i_req = '0; bus.i_lock = '0; bus.i_op = '0; bus.i_a = '0; bus.i_b = '0;
    #1;
    chk("rst_grant", 32'(bus.o_grant), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_start", 32'(bus.o_alu_start), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_result", 32'(bus.o_result), 0);
    tick(); tick();
    rst = 1'b0;

    // Table: single requests, full timeline per op.
    for (int v = 0; v < 6; v++) begin
      set_ops(vt[v].idx, vt[v].op, vt[v].a, vt[v].b);
      bus.i_req = 4'(1 << vt[v].idx);
      tick();
      chk("vec_grant", 32'(bus.o_grant), 32'(1 << vt[v].idx));
      chk("vec_start", 32'(bus.o_alu_start), 1);
      chk("vec_alu_op", 32'(bus.o_alu_op), 32'(vt[v].op));
      chk("vec_alu_a", 32'(bus.o_alu_a), 32'(vt[v].a));
      chk("vec_alu_b", 32'(bus.o_alu_b), 32'(vt[v].b));
      tick();
      chk("vec_wait_start", 32'(bus.o_alu_start), 0);
      chk("vec_wait_done", 32'(bus.o_done), 0);
      tick();
      chk("vec_wait2_done", 32'(bus.o_done), 0);
      chk("vec_wait2_busy", 32'(bus.o_busy), 1);
      tick();
      chk("vec_done", 32'(bus.o_done), 32'(1 << vt[v].idx));
      chk("vec_result", 32'(bus.o_result), 32'(vt[v].exp_res));
      chk("vec_done_grant", 32'(bus.o_grant), 32'(1 << vt[v].idx));
      bus.i_req = '0;
      tick();
      chk("vec_idle_busy", 32'(bus.o_busy), 0);
      chk("vec_idle_done", 32'(bus.o_done), 0);
      chk("vec_idle_grant", 32'(bus.o_grant), 0);
      chk("vec_hold_result", 32'(bus.o_result), 32'(vt[v].exp_res));
      chk("vec_hold_alu_a", 32'(bus.o_alu_a), 32'(vt[v].a));
    end

    // All four requesting continuously: 0,1,2,3,0 every 5 cycles.
    do_reset();
    for (int r = 0; r < NREQ; r++) set_ops(r, OP_ADD, 16'(16'h0100 * (r + 1)), 16'(r));
    bus.i_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr_grant", 32'(bus.o_grant), 32'(1 << (n % 4)));
      chk("rr_start", 32'(bus.o_alu_start), 1);
      tick(); tick(); tick();
      chk("rr_done", 32'(bus.o_done), 32'(1 << (n % 4)));
      chk("rr_result", 32'(bus.o_result),
          32'(alu_f(OP_ADD, 16'(16'h0100 * ((n % 4) + 1)), 16'(n % 4))));
      tick();
      chk("rr_idle", 32'(bus.o_busy), 0);
    end
    bus.i_req = '0;
    tick(); tick(); tick(); tick(); tick();

    // Requester 1 drops its request after grant.
    do_reset();
    set_ops(1, OP_SUB, 16'h0050, 16'h0008);
    bus.i_req = 4'b0010;
    tick();
    chk("drop_grant", 32'(bus.o_grant), 32'h2);
    tick();
    bus.i_req = '0;
    tick(); tick();
    chk("drop_done", 32'(bus.o_done), 32'h2);
    chk("drop_result", 32'(bus.o_result), 32'h0048);
    tick(); tick();
    chk("drop_no_regrant", 32'(bus.o_grant), 0);
    chk("drop_no_busy", 32'(bus.o_busy), 0);

    // Operands change after the issue cycle.
    set_ops(0, OP_ADD, 16'h0005, 16'h0006);
    bus.i_req = 4'b0001;
    tick(); tick();
    set_ops(0, OP_ADD, 16'h0100, 16'h0200);
    tick(); tick();
    chk("latch_done", 32'(bus.o_done), 32'h1);
    chk("latch_result", 32'(bus.o_result), 32'h000B);
    chk("latch_alu_a", 32'(bus.o_alu_a), 32'h0005);
    bus.i_req = '0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    set_ops(2, OP_ADD, 16'h0011, 16'h0022);
    set_ops(0, OP_XOR, 16'h00F0, 16'h000F);
    bus.i_req = 4'b0100;
    tick(); tick();
    chk("mid_busy_before", 32'(bus.o_busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_grant", 32'(bus.o_grant), 0);
    chk("mid_busy", 32'(bus.o_busy), 0);
    chk("mid_done", 32'(bus.o_done), 0);
    chk("mid_result", 32'(bus.o_result), 0);
    chk("mid_alu_a", 32'(bus.o_alu_a), 0);
    chk("mid_alu_op", 32'(bus.o_alu_op), 0);
    bus.i_req = 4'b0101;
    tick();
    chk("mid_held_done", 32'(bus.o_done), 0);
    rst = 1'b0;
    bus.i_req = 4'b0001;
    tick();
    chk("mid_post_grant", 32'(bus.o_grant), 32'h1);
    tick(); tick(); tick();
    chk("mid_post_done", 32'(bus.o_done), 32'h1);
    chk("mid_post_result", 32'(bus.o_result), 32'h00FF);
    bus.i_req = '0;
    tick();

    // Lock: requester 3 holds iLock, requester 0 joins after the first grant.
    do_reset();
    set_ops(3, OP_ADD, 16'h3000, 16'h0003);
    set_ops(0, OP_ADD, 16'h0000, 16'h0001);
    bus.i_req  = 4'b1000;
    bus.i_lock = 4'b1000;
    tick();
    bus.i_req = 4'b1001;
    nst = 0; run = 0; cont = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (nst < 5 && bus.o_alu_start) begin
        own[nst] = owner(bus.o_grant);
        nst++;
      end
      if (cont && bus.o_grant == 4'b1000) run++;
      else cont = 1'b0;
      tick();
    end
`ifdef ARB_LOCK_EN
    exp_own = '{3, 3, 3, 3, 0};
    exp_run = 16;
`else
    exp_own = '{3, 0, 3, 0, 3};
    exp_run = 4;
`endif
    chk("lock_nstarts", 32'(nst), 5);
    for (int s = 0; s < 5; s++) chk("lock_owner", 32'(own[s]), 32'(exp_own[s]));
    chk("lock_grant_run", 32'(run), 32'(exp_run));
    bus.i_req = '0; bus.i_lock = '0;
    for (int c = 0; c < 20 && bus.o_busy; c++) tick();
    chk("lock_end_idle", 32'(bus.o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
